// File: rtl/can_sched_pkg.sv
// Shared constants and types for the CAN TX scheduler: payload width,
// output-register state encoding and the slot index width helper.
package can_sched_pkg;

    localparam int CAN_TX_DW = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } tx_state_e;

    // Never returns 0 so a 1-slot build would still get a legal index port.
    function automatic int slot_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/can_sched_slot.sv
// One periodic mailbox slot: stored config/payload, tick counter,
// pending flag and sticky overrun flag.
module can_sched_slot
    import can_sched_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 cfg_we,
    input  logic                 cfg_en,
    input  logic [PERIOD_W-1:0]  cfg_period,
    input  logic [CAN_TX_DW-1:0] cfg_data,
    input  logic                 grant,
    input  logic                 clr,
    output logic                 pending,
    output logic                 overrun,
    output logic [CAN_TX_DW-1:0] data
);

    logic                 en_q, en_d;
    logic [PERIOD_W-1:0]  period_q, period_d;
    logic [CAN_TX_DW-1:0] data_q, data_d;
    logic [PERIOD_W-1:0]  cnt_q, cnt_d;
    logic                 pending_q, pending_d;
    logic                 overrun_q, overrun_d;
    logic                 active;
    logic                 fire;

    always_comb begin
        active    = en_q & (period_q != '0);
        // A config write on this slot masks any same-cycle tick effect.
        fire      = ~cfg_we & tick & active & (cnt_q == period_q - 1'b1);
        en_d      = en_q;
        period_d  = period_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        if (cfg_we) begin
            en_d      = cfg_en;
            period_d  = cfg_period;
            data_d    = cfg_data;
            cnt_d     = '0;
            pending_d = 1'b0;
        end else begin
            if (tick & active) begin
                cnt_d = fire ? '0 : cnt_q + 1'b1;
            end
            // A fire on the granted cycle re-arms pending: the old frame was consumed.
            if (fire) begin
                pending_d = 1'b1;
            end else if (grant) begin
                pending_d = 1'b0;
            end
        end
        overrun_d = (fire & pending_q & ~grant) | (overrun_q & ~clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q      <= 1'b0;
            period_q  <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            en_q      <= en_d;
            period_q  <= period_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending = pending_q;
    assign overrun = overrun_q;
    assign data    = data_q;

endmodule

// File: rtl/can_tx_scheduler.sv
// Feeds the CAN controller TX push port from periodic mailbox slots and an
// immediate host port: immediate has absolute priority, slots are round-robin.
module can_tx_scheduler
    import can_sched_pkg::*;
#(
    parameter  int NUM_SLOTS = 4,
    parameter  int TICK_DIV  = 50000,
    parameter  int PERIOD_W  = 16,
    localparam int SW        = slot_idx_w(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [SW-1:0]        cfg_slot,
    input  logic                 cfg_en,
    input  logic [PERIOD_W-1:0]  cfg_period,
    input  logic [CAN_TX_DW-1:0] cfg_data,
    input  logic                 imm_valid,
    output logic                 imm_ready,
    input  logic [CAN_TX_DW-1:0] imm_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [CAN_TX_DW-1:0] tx_data,
    output logic [NUM_SLOTS-1:0] slot_pending,
    output logic [NUM_SLOTS-1:0] slot_overrun,
    input  logic [NUM_SLOTS-1:0] overrun_clr,
    output tx_state_e            dbg_state
);

    localparam int PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0]     presc_q, presc_d;
    logic                 tick;
    tx_state_e            state_q, state_d;
    logic [CAN_TX_DW-1:0] tx_data_q, tx_data_d;
    logic [SW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_SLOTS-1:0] cfg_mask;
    logic [NUM_SLOTS-1:0] cand;
    logic [NUM_SLOTS-1:0] slot_grant;
    logic [CAN_TX_DW-1:0] slot_data [NUM_SLOTS];
    logic                 load;
    logic                 found;
    logic [SW-1:0]        gnt_idx;
    logic [SW-1:0]        idx;

    always_comb begin
        tick    = (presc_q == PRE_W'(TICK_DIV - 1));
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    always_comb begin
        cfg_mask = '0;
        if (cfg_we) begin
            cfg_mask[cfg_slot] = 1'b1;
        end
    end

    // Handshakes: a beat transfers on a cycle where valid && ready. tx_valid/tx_data
    // stay frozen while tx_ready is low; imm_ready is the combinational accept.
    always_comb begin
        load      = (state_q == ST_IDLE) | tx_ready;
        cand      = slot_pending & ~cfg_mask;
        found     = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            idx = rr_ptr_q + SW'(i);
            if (!found && cand[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        imm_ready  = ~rst & load & imm_valid;
        slot_grant = '0;
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        rr_ptr_d   = rr_ptr_q;
        if (load) begin
            if (imm_valid) begin
                state_d   = ST_HOLD;
                tx_data_d = imm_data;
            end else if (found) begin
                state_d             = ST_HOLD;
                tx_data_d           = slot_data[gnt_idx];
                rr_ptr_d            = gnt_idx + 1'b1;
                slot_grant[gnt_idx] = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            state_q   <= ST_IDLE;
            tx_data_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            presc_q   <= presc_d;
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        can_sched_slot #(
            .PERIOD_W(PERIOD_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .cfg_we    (cfg_mask[s]),
            .cfg_en    (cfg_en),
            .cfg_period(cfg_period),
            .cfg_data  (cfg_data),
            .grant     (slot_grant[s]),
            .clr       (overrun_clr[s]),
            .pending   (slot_pending[s]),
            .overrun   (slot_overrun[s]),
            .data      (slot_data[s])
        );
    end

    assign tx_valid  = (state_q == ST_HOLD);
    assign tx_data   = tx_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Self-checking bench for can_tx_scheduler: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_can_tx_scheduler;
    import can_sched_pkg::*;

    localparam int NS = 4;
    localparam int TD = 4;
    localparam int PW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_slot;
    logic        cfg_en;
    logic [PW-1:0] cfg_period;
    logic [31:0] cfg_data;
    logic        imm_valid;
    logic        imm_ready;
    logic [31:0] imm_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] tx_data;
    logic [NS-1:0] slot_pending;
    logic [NS-1:0] slot_overrun;
    logic [NS-1:0] overrun_clr;
    tx_state_e   dbg_state;

    always #5 clk = ~clk;

    can_tx_scheduler #(.NUM_SLOTS(NS), .TICK_DIV(TD), .PERIOD_W(PW)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_en(cfg_en),
        .cfg_period(cfg_period), .cfg_data(cfg_data), .imm_valid(imm_valid),
        .imm_ready(imm_ready), .imm_data(imm_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .slot_pending(slot_pending),
        .slot_overrun(slot_overrun), .overrun_clr(overrun_clr), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] log_q[$];
    int          log_t[$];
    logic [31:0] exp_q[$];
    logic        last_imm_ready;

    // Behavioural model: time in ticks, slots as plain integer counters.
    int          m_presc;
    int          m_rr;
    bit          m_valid;
    logic [31:0] m_data;
    bit          m_en[NS];
    int          m_per[NS];
    logic [31:0] m_dat[NS];
    int          m_cnt[NS];
    bit          m_pend[NS];
    bit          m_ovr[NS];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        m_presc = 0; m_rr = 0; m_valid = 0; m_data = '0;
        for (int s = 0; s < NS; s++) begin
            m_en[s] = 0; m_per[s] = 0; m_dat[s] = '0; m_cnt[s] = 0; m_pend[s] = 0; m_ovr[s] = 0;
        end
    endfunction

    function automatic logic [NS-1:0] m_pend_vec();
        logic [NS-1:0] v;
        for (int s = 0; s < NS; s++) v[s] = m_pend[s];
        return v;
    endfunction

    function automatic logic [NS-1:0] m_ovr_vec();
        logic [NS-1:0] v;
        for (int s = 0; s < NS; s++) v[s] = m_ovr[s];
        return v;
    endfunction

    function automatic bit m_imm_ready();
        return imm_valid && (!m_valid || tx_ready);
    endfunction

    function automatic void model_step();
        bit tick;
        bit load;
        bit fire;
        bit set;
        int g;
        tick = (m_presc == TD - 1);
        load = !m_valid || tx_ready;
        g = -1;
        if (load && !imm_valid) begin
            for (int k = 0; k < NS; k++) begin
                int s;
                s = (m_rr + k) % NS;
                if (g < 0 && m_pend[s] && !(cfg_we && int'(cfg_slot) == s)) g = s;
            end
        end
        if (load) begin
            if (imm_valid) begin
                m_valid = 1; m_data = imm_data;
            end else if (g >= 0) begin
                m_valid = 1; m_data = m_dat[g]; m_rr = (g + 1) % NS;
            end else begin
                m_valid = 0;
            end
        end
        for (int s = 0; s < NS; s++) begin
            set = 0;
            if (cfg_we && int'(cfg_slot) == s) begin
                m_en[s] = cfg_en; m_per[s] = int'(cfg_period); m_dat[s] = cfg_data;
                m_cnt[s] = 0; m_pend[s] = 0;
            end else begin
                fire = tick && m_en[s] && m_per[s] != 0 && m_cnt[s] == m_per[s] - 1;
                if (tick && m_en[s] && m_per[s] != 0) m_cnt[s] = fire ? 0 : m_cnt[s] + 1;
                if (fire) begin
                    set = m_pend[s] && (g != s);
                    m_pend[s] = 1;
                end else if (g == s) begin
                    m_pend[s] = 0;
                end
            end
            m_ovr[s] = set || (m_ovr[s] && !overrun_clr[s]);
        end
        m_presc = (m_presc + 1) % TD;
    endfunction

    // Inputs are set by the caller shortly after a rising edge.
    task automatic cycle();
        @(negedge clk);
        last_imm_ready = imm_ready;
        chk("imm_ready", 32'(imm_ready), 32'(m_imm_ready()));
        if (tx_valid && tx_ready) begin
            log_q.push_back(tx_data);
            log_t.push_back(cyc);
        end
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        chk("tx_valid", 32'(tx_valid), 32'(m_valid));
        if (m_valid) chk("tx_data", tx_data, m_data);
        chk("slot_pending", 32'(slot_pending), 32'(m_pend_vec()));
        chk("slot_overrun", 32'(slot_overrun), 32'(m_ovr_vec()));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_we = 0; cfg_slot = 0; cfg_en = 0; cfg_period = 0; cfg_data = 0;
        imm_valid = 0; imm_data = 0; tx_ready = 0; overrun_clr = 0;
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", tx_data, 32'd0);
        chk("rst_pending", 32'(slot_pending), 32'd0);
        chk("rst_overrun", 32'(slot_overrun), 32'd0);
        chk("rst_imm_ready", 32'(imm_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cfg_write(input int slot, input bit en, input int period, input logic [31:0] data);
        cfg_slot = 2'(slot); cfg_en = en; cfg_period = PW'(period); cfg_data = data; cfg_we = 1;
        cycle();
        cfg_we = 0;
    endtask

    task automatic compare_log(string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < log_q.size()) chk(name, log_q[i], exp_q[i]);
            else chk({name, "_missing"}, 32'(log_q.size()), 32'(exp_q.size()));
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] idata;
        logic        tr;
        logic        exp_ir;
        logic        exp_v;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h1111_2222, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 32'h1111_2222, 1'b1, 1'b1, 1'b1, 32'h1111_2222};
        vecs[4] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h1111_2222};
        vecs[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 32'h3333_4444, 1'b1, 1'b1, 1'b1, 32'h3333_4444};
        vecs[7] = '{1'b1, 32'h5555_6666, 1'b1, 1'b1, 1'b1, 32'h5555_6666};
        vecs[8] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0};

        // Reset and immediate-port vectors with all slots disabled.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            imm_valid = vecs[i].iv; imm_data = vecs[i].idata; tx_ready = vecs[i].tr;
            cycle();
            chk("vec_imm_ready", 32'(last_imm_ready), 32'(vecs[i].exp_ir));
            chk("vec_tx_valid", 32'(tx_valid), 32'(vecs[i].exp_v));
            if (vecs[i].exp_v) chk("vec_tx_data", tx_data, vecs[i].exp_d);
        end
        imm_valid = 0;

        // Slot0 period 3 ticks = 12 clk between frames.
        do_reset();
        tx_ready = 1;
        cfg_write(0, 1, 3, 32'hA5A5_0001);
        log_q.delete(); log_t.delete();
        repeat (70) cycle();
        chk("s2_count", 32'(log_q.size() >= 5), 32'd1);
        for (int i = 0; i < log_q.size(); i++) chk("s2_data", log_q[i], 32'hA5A5_0001);
        for (int i = 1; i < log_t.size(); i++) chk("s2_interval", 32'(log_t[i] - log_t[i-1]), 32'd12);

        // Immediate request on the cycle slot2 turns pending goes first.
        do_reset();
        tx_ready = 1;
        cfg_write(2, 1, 1, 32'hC0DE_0002);
        n = 0;
        while (!slot_pending[2] && n < 20) begin cycle(); n++; end
        chk("s3_slot2_pending", 32'(slot_pending[2]), 32'd1);
        log_q.delete();
        imm_valid = 1; imm_data = 32'hDEAD_BEEF;
        cycle();
        imm_valid = 0;
        repeat (3) cycle();
        exp_q.delete();
        exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(32'hC0DE_0002);
        compare_log("s3_order");
        cfg_write(2, 0, 0, 32'h0);

        // All four slots pending: round-robin 0..3, then slot1 after wrap.
        do_reset();
        imm_valid = 1; imm_data = 32'h1111_1111;
        cycle();
        imm_valid = 0;
        for (int s = 0; s < NS; s++) cfg_write(s, 1, (s == 1) ? 1 : 8, 32'h5100_0000 + 32'(s));
        n = 0;
        while (slot_pending != 4'hF && n < 100) begin cycle(); n++; end
        chk("s4_all_pending", 32'(slot_pending), 32'hF);
        log_q.delete();
        tx_ready = 1;
        n = 0;
        while (log_q.size() < 6 && n < 60) begin cycle(); n++; end
        exp_q.delete();
        exp_q.push_back(32'h1111_1111);
        for (int s = 0; s < NS; s++) exp_q.push_back(32'h5100_0000 + 32'(s));
        exp_q.push_back(32'h5100_0001);
        compare_log("s4_rr");

        // Backpressure: held output stays stable while slot1 overruns.
        do_reset();
        cfg_write(1, 1, 1, 32'h0B0B_0001);
        n = 0;
        while (!tx_valid && n < 20) begin cycle(); n++; end
        chk("s5_hold_valid", 32'(tx_valid), 32'd1);
        for (int i = 0; i < 40; i++) begin
            cycle();
            chk("s5_stable", tx_data, 32'h0B0B_0001);
        end
        chk("s5_overrun_set", 32'(slot_overrun[1]), 32'd1);
        cfg_write(1, 0, 0, 32'h0);
        overrun_clr = 4'b0010;
        cycle();
        overrun_clr = 4'b0000;
        chk("s5_overrun_clr", 32'(slot_overrun[1]), 32'd0);
        tx_ready = 1;
        repeat (4) cycle();

        // Reset while holding a frame drops tx_valid at once; slots stay silent.
        cfg_write(0, 1, 1, 32'h6600_0000);
        tx_ready = 0;
        n = 0;
        while (!tx_valid && n < 20) begin cycle(); n++; end
        chk("s6_pre_valid", 32'(tx_valid), 32'd1);
        do_reset();
        tx_ready = 1;
        log_q.delete();
        repeat (30) cycle();
        chk("s6_no_frames", 32'(log_q.size()), 32'd0);
        chk("s6_no_pending", 32'(slot_pending), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cfg_we      = ($urandom_range(0, 15) == 0);
            cfg_slot    = 2'($urandom_range(0, NS - 1));
            cfg_en      = ($urandom_range(0, 3) != 0);
            cfg_period  = PW'($urandom_range(0, 4));
            cfg_data    = $urandom;
            imm_valid   = ($urandom_range(0, 5) == 0);
            imm_data    = $urandom;
            tx_ready    = ($urandom_range(0, 3) != 0);
            overrun_clr = ($urandom_range(0, 7) == 0) ? NS'($urandom_range(0, 15)) : '0;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
